// File: rtl/conv2d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_pkg
// Purpose  : Shared types and constants for the conv2d input-side feeder.
// Revision : 1.0 - initial release
// ============================================================================
package conv2d_pkg;

   localparam int            DW      = 32;
   localparam logic [DW-1:0] FP_ZERO = 32'h0;

   localparam int ERR_PSUM_UNDERRUN = 0;
   localparam int ERR_OUT_COUNT     = 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PARAM  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/conv2d_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_feeder_if
// Purpose  : Source pixel, partial-sum and output sink streams of the feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface conv2d_feeder_if;
   import conv2d_pkg::*;

   logic          src_valid;
   logic [DW-1:0] src_data;
   logic          src_ready;
   logic          psum_valid;
   logic [DW-1:0] psum_data;
   logic          psum_ready;
   logic          dst_valid;
   logic [DW-1:0] dst_data;

   modport master (
      output src_valid, src_data, psum_valid, psum_data,
      input  src_ready, psum_ready, dst_valid, dst_data
   );

   modport slave (
      input  src_valid, src_data, psum_valid, psum_data,
      output src_ready, psum_ready, dst_valid, dst_data
   );

endinterface
`default_nettype wire

// File: rtl/conv2d_psum_fifo.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_psum_fifo
// Purpose  : Show-ahead synchronous FIFO prefetching partial sums for the core.
// Revision : 1.0 - initial release
// ============================================================================
module conv2d_psum_fifo
   import conv2d_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          i_flush,
   input  wire logic          i_push,
   input  wire logic [DW-1:0] i_wr_data,
   input  wire logic          i_pop,
   output logic      [DW-1:0] o_rd_data,
   output logic               o_full,
   output logic               o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          w_push;
   logic          w_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push    = i_push && !o_full;
   assign w_pop     = i_pop && !o_empty;
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/conv2d_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_feeder
// Purpose  : Programs conv2d_core, streams one channel frame and partial sums.
//            Optional stall counter enabled by CONV2D_FEEDER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv2d_feeder
   import conv2d_pkg::*;
#(
   parameter int C_WIDTH  = 9,
   parameter int PF_DEPTH = 16
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   input  wire logic               cfg_start,
   input  wire logic [C_WIDTH-1:0] cfg_width_in,
   input  wire logic [C_WIDTH-1:0] cfg_height_in,
   input  wire logic               cfg_first,
   output logic                    busy,
   output logic                    done,
   output logic      [1:0]         err,
   conv2d_feeder_if.slave          strm,
   output logic                    param_ena,
   output logic      [C_WIDTH-1:0] param_width_in,
   output logic      [C_WIDTH-1:0] param_height_out,
   output logic                    pxl_ena_x,
   output logic      [DW-1:0]      pxl_x,
   input  wire logic               pxl_ena_y,
   output logic      [DW-1:0]      pxl_y,
   input  wire logic               pxl_ena_z,
   input  wire logic [DW-1:0]      pxl_z,
`ifdef CONV2D_FEEDER_STATS_EN
   output logic      [31:0]        stat_stall,
`endif
   input  wire logic               pxl_ovr
);

   localparam int             CW2   = 2 * C_WIDTH;
   localparam logic [CW2-1:0] c_one = CW2'(1);

   state_t             r_state, w_state_nxt;
   logic [C_WIDTH-1:0] r_width, r_height, r_param_height;
   logic               r_first, r_settle;
   logic [CW2-1:0]     r_x_cnt, r_z_cnt, w_x_cnt_nxt, w_z_cnt_nxt;
   logic [CW2-1:0]     w_x_total, w_z_total;
   logic [1:0]         r_err;
   logic               r_pxl_ena_x, r_dst_valid;
   logic [DW-1:0]      r_pxl_x, r_pxl_y, r_dst_data;
   logic               w_busy, w_start, w_src_ready, w_src_acc, w_abort;
   logic               w_psum_ready, w_pop, w_underrun, w_enter_done;
   logic [DW-1:0]      w_fifo_data;
   logic               w_fifo_full, w_fifo_empty;

   assign w_busy      = (r_state != ST_IDLE);
   assign w_start     = cfg_start && !w_busy;
   assign w_x_total   = CW2'(r_width) * CW2'(r_height);
   assign w_z_total   = CW2'(r_width - C_WIDTH'(2)) * CW2'(r_param_height);
   assign w_src_ready = (r_state == ST_STREAM) && (r_x_cnt < w_x_total) && !pxl_ovr;
   assign w_src_acc   = w_src_ready && strm.src_valid;
   // End-of-frame while pixels are still owed means the core gave up early.
   assign w_abort     = (r_state == ST_STREAM) && pxl_ovr && (r_x_cnt < w_x_total);
   assign w_x_cnt_nxt = r_x_cnt + (w_src_acc ? c_one : '0);
   assign w_z_cnt_nxt = r_z_cnt + ((pxl_ena_z && w_busy) ? c_one : '0);
   assign w_psum_ready = !w_fifo_full && !r_first && !w_abort &&
                         ((r_state == ST_SETTLE) || (r_state == ST_STREAM) ||
                          (r_state == ST_DRAIN));
   assign w_pop        = pxl_ena_y && w_busy && !r_first && !w_fifo_empty;
   assign w_underrun   = pxl_ena_y && w_busy && !r_first && w_fifo_empty;
   assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_start) w_state_nxt = ST_PARAM;
         ST_PARAM:  w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (r_settle) w_state_nxt = ST_STREAM;
         ST_STREAM: begin
            if (pxl_ovr)                       w_state_nxt = ST_DONE;
            else if (w_x_cnt_nxt == w_x_total) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN:  if (pxl_ovr) w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_width        <= '0;
         r_height       <= '0;
         r_param_height <= '0;
         r_first        <= 1'b0;
         r_settle       <= 1'b0;
         r_x_cnt        <= '0;
         r_z_cnt        <= '0;
         r_err          <= '0;
      end else begin
         r_settle <= (r_state == ST_SETTLE) ? !r_settle : 1'b0;
         if (w_start) begin
            r_width        <= cfg_width_in;
            r_height       <= cfg_height_in;
            r_param_height <= cfg_height_in - C_WIDTH'(2);
            r_first        <= cfg_first;
            r_x_cnt        <= '0;
            r_z_cnt        <= '0;
            r_err          <= '0;
         end else begin
            r_x_cnt <= w_x_cnt_nxt;
            r_z_cnt <= w_z_cnt_nxt;
            if (w_underrun) r_err[ERR_PSUM_UNDERRUN] <= 1'b1;
            if (w_enter_done && (w_z_cnt_nxt != w_z_total)) r_err[ERR_OUT_COUNT] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pxl_ena_x <= 1'b0;
         r_pxl_x     <= '0;
         r_pxl_y     <= FP_ZERO;
         r_dst_valid <= 1'b0;
         r_dst_data  <= '0;
      end else begin
         r_pxl_ena_x <= w_src_acc;
         r_dst_valid <= pxl_ena_z;
         if (w_src_acc)           r_pxl_x    <= strm.src_data;
         if (pxl_ena_z)           r_dst_data <= pxl_z;
         if (pxl_ena_y && w_busy) r_pxl_y    <= w_pop ? w_fifo_data : FP_ZERO;
      end
   end

   conv2d_psum_fifo #(
      .DEPTH (PF_DEPTH)
   ) u_psum_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_flush   (w_abort),
      .i_push    (strm.psum_valid && w_psum_ready),
      .i_wr_data (strm.psum_data),
      .i_pop     (w_pop),
      .o_rd_data (w_fifo_data),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

`ifdef CONV2D_FEEDER_STATS_EN
   logic [31:0] r_stat_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                             r_stat_stall <= '0;
      else if (w_start)                                       r_stat_stall <= '0;
      else if (w_src_ready && !strm.src_valid && !(&r_stat_stall)) r_stat_stall <= r_stat_stall + 32'd1;
   end

   assign stat_stall = r_stat_stall;
`endif

   assign busy             = w_busy;
   assign done             = (r_state == ST_DONE);
   assign err              = r_err;
   assign param_ena        = (r_state == ST_PARAM);
   assign param_width_in   = r_width;
   assign param_height_out = r_param_height;
   assign pxl_ena_x        = r_pxl_ena_x;
   assign pxl_x            = r_pxl_x;
   assign pxl_y            = r_pxl_y;
   assign strm.src_ready   = w_src_ready;
   assign strm.psum_ready  = w_psum_ready;
   assign strm.dst_valid   = r_dst_valid;
   assign strm.dst_data    = r_dst_data;

endmodule
`default_nettype wire

// File: doc/conv2d_feeder.md
# conv2d_feeder

Stream controller on the input side of `conv2d_core`. It programs the core, feeds it one input-channel frame as a pixel stream, and supplies the previous-channel partial sums the core requests. It also returns the core's output pixels to a downstream sink and signals completion when the core reports frame overflow. It sits between the DMA/line-memory source streams and the convolution core.

## Interface
- `C_WIDTH`, 9: width of the dimension and counter fields.
- `PF_DEPTH`, 16: depth of the partial-sum prefetch FIFO; must be a power of 2.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: one-cycle start pulse; latches all `cfg_*` inputs. Ignored while `busy`.
- `cfg_width_in` in C_WIDTH: input frame width, ≥3.
- `cfg_height_in` in C_WIDTH: input frame height, ≥3.
- `cfg_first` in 1: first input channel; partial sums are forced to 0.0 and `psum_*` is never read.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 2: sticky error flags, cleared on `cfg_start`. Bit 0 = psum underrun; bit 1 = output count mismatch.
- `src_valid` in 1, `src_data` in 32, `src_ready` out 1: input pixel stream.
- `psum_valid` in 1, `psum_data` in 32, `psum_ready` out 1: previous partial-sum stream.
- `param_ena` out 1: parameter-load pulse to the core.
- `param_width_in` out C_WIDTH: width parameter to the core.
- `param_height_out` out C_WIDTH: output-height parameter to the core.
- `pxl_ena_x` out 1, `pxl_x` out 32: pixel stream to the core.
- `pxl_ena_y` in 1: partial-sum request from the core.
- `pxl_y` out 32: partial-sum value to the core.
- `pxl_ena_z` in 1, `pxl_z` in 32: output pixels from the core.
- `pxl_ovr` in 1: end-of-frame from the core.
- `dst_valid` out 1, `dst_data` out 32: output sink. There is no backpressure.

## Operation
- State machine states: IDLE, PARAM, SETTLE, STREAM, DRAIN, DONE.
- IDLE: on `cfg_start`, latch the configuration, clear `err` and all counters, then go to PARAM.
- PARAM: drive `param_ena`=1 for exactly 1 cycle, then go to SETTLE.
- SETTLE: hold for 2 cycles, because the core registers its parameters, then go to STREAM.
- STREAM:
  - `src_ready` = 1 while `x_cnt` < width_in·height_in.
  - Each accepted beat increments `x_cnt`.
  - When `x_cnt` reaches the total, go to DRAIN.
- DRAIN: wait for `pxl_ovr`, then go to DONE.
- DONE: pulse `done` for 1 cycle, then go to IDLE. `busy` = 1 in every state except IDLE.
- Parameter outputs: `param_width_in` = width_in, and `param_height_out` = height_in − 2. Both are held stable from PARAM until the next start.
- Partial sums:
  - Prefetch FIFO filled from `psum_*`; `psum_ready` = FIFO not full and state ∈ {SETTLE, STREAM, DRAIN} and not `cfg_first`.
  - On `pxl_ena_y`, pop one entry and register it to `pxl_y`.
  - If the FIFO is empty on `pxl_ena_y`: `pxl_y` = 0, set `err[0]`.
  - With `cfg_first` set: `pxl_y` = 32'h0 always.
- Output path:
  - `dst_valid`/`dst_data` are `pxl_ena_z`/`pxl_z` registered.
  - `z_cnt` counts `pxl_ena_z`.
  - On entering DONE, set `err[1]` if `z_cnt` ≠ (width_in−2)·(height_in−2).
  - `pxl_ena_z` arriving after DONE is still forwarded.
- Counter widths: `x_cnt` and `z_cnt` are 2·C_WIDTH bits and never wrap, because the maximum is 511·511.
- `pxl_ovr` before STREAM completes: abort. Go to DONE at once, stop `src_ready`, and flush the FIFO.

## Timing
- `pxl_ena_x`/`pxl_x` appear 1 cycle after the `src_valid & src_ready` handshake.
- `pxl_y` is valid in cycle N+1 for `pxl_ena_y` in cycle N, and holds until the next request.
- `dst_valid` appears 1 cycle after `pxl_ena_z`.
- Start to first `src_ready`: 4 cycles (start, PARAM, SETTLE×2).
- FIFO push and pop in the same cycle are both performed. Pop from empty is a no-op that sets `err[0]`.
- Reset values: all outputs 0, state IDLE, FIFO empty. Reset mid-frame returns to IDLE with no `done` pulse.

## Configuration
- Macro: `CONV2D_FEEDER_STATS_EN`.
- When defined: adds output `stat_stall` [31:0], counting STREAM cycles with `src_ready`=1 and `src_valid`=0. It is cleared on `cfg_start` and saturates at all ones.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Package `conv2d_pkg`: state enum, `DW`=32, `FP_ZERO`=32'h0, error bit indices.
- Sub-module `conv2d_psum_fifo`: show-ahead synchronous FIFO (`PF_DEPTH` × 32) with full/empty, async active-low reset.

## Test plan
- 5×5 frame, `cfg_first`=1, source always valid:
  - 25 `pxl_ena_x` pulses; `param_height_out`=3.
  - All `pxl_y` = 0; `psum_ready` never asserted.
  - After `pxl_ovr`: `done` pulse, `err`=0.
- 5×5 frame, `cfg_first`=0, psum values 1.0…9.0:
  - Each `pxl_ena_y` returns the next value 1 cycle later.
  - 9 `dst_valid` beats.
- psum source held invalid: the first `pxl_ena_y` gives `pxl_y`=0 and `err[0]`=1.
- Source toggling valid every other cycle:
  - `pxl_ena_x` count is still 25 for a 5×5 frame.
  - `stat_stall`=24 with `CONV2D_FEEDER_STATS_EN` defined.
- `pxl_ovr` injected after 10 pixels: `src_ready` drops, `done` pulses next cycle, `err[1]`=1.
- `rst_n` low mid-STREAM: all outputs 0 and IDLE; a new `cfg_start` runs a full 3×3 frame correctly.
